// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: owns HI/LO, sequences multi-cycle mult/div
// through a down-counter, and raises a D-stage stall while work is pending.
module mdu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_in_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [31:0]   a_q, b_q;
    logic          start_op, last_cyc;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   b_safe, quo_s, rem_s, quo_u, rem_u;
    logic [31:0]   hi_res, lo_res;

    assign start_op = (state == IDLE) && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign last_cyc = (state == BUSY) && (cnt == CW'(1));
    assign busy     = (state == BUSY);
    assign stall_md = md_in_d & (busy | ((md_op >= OP_MULT) && (md_op <= OP_DIVU)));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        md_rdata = 32'd0;
        if (md_op == OP_MFHI)      md_rdata = hi;
        else if (md_op == OP_MFLO) md_rdata = lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_op) state_nxt = BUSY;
            BUSY:    if (last_cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    // A zero divisor discards the result anyway; substituting 1 keeps the dividers defined.
    assign b_safe = (b_q == 32'd0) ? 32'd1 : b_q;
    assign quo_s  = $signed(a_q) / $signed(b_safe);
    assign rem_s  = $signed(a_q) % $signed(b_safe);
    assign quo_u  = a_q / b_safe;
    assign rem_u  = a_q % b_safe;

    always_comb begin
        hi_res = hi;
        lo_res = lo;
        case (op_q)
            OP_MULT:  {hi_res, lo_res} = prod_s;
            OP_MULTU: {hi_res, lo_res} = prod_u;
            OP_DIV: begin
                if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                    lo_res = 32'h8000_0000;
                    hi_res = 32'd0;
                end else if (b_q != 32'd0) begin
                    lo_res = quo_s;
                    hi_res = rem_s;
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    lo_res = quo_u;
                    hi_res = rem_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= 4'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else if (state == IDLE) begin
            if (start_op) begin
                cnt  <= (md_op <= OP_MULTU) ? CW'(MULT_CYC) : CW'(DIV_CYC);
                op_q <= md_op;
                a_q  <= rs_data;
                b_q  <= rt_data;
            end else if (md_op == OP_MTHI) begin
                hi <= rs_data;
            end else if (md_op == OP_MTLO) begin
                lo <= rs_data;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (last_cyc) begin
                hi <= hi_res;
                lo <= lo_res;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: table of mult/div vectors plus hand-written
// sequences for stalls, mid-operation reset and back-to-back issue.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        md_in_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .md_in_d  (md_in_d),
        .busy     (busy),
        .stall_md (stall_md),
        .md_rdata (md_rdata),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cyc;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one multi-cycle op from IDLE, scramble the operands afterwards,
    // and check busy length, HI/LO hold while busy, final result and reads.
    task automatic run_op(input vec_t v);
        int          n;
        logic        moved;
        logic [31:0] hi0, lo0;
        hi0     = hi;
        lo0     = lo;
        moved   = 1'b0;
        md_op   = v.op;
        rs_data = v.rs;
        rt_data = v.rt;
        tick;
        md_op   = 4'd0;
        rs_data = $urandom;
        rt_data = $urandom;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (hi !== hi0 || lo !== lo0) moved = 1'b1;
            tick;
        end
        check("busy_cycles", n, v.cyc);
        check("hold_while_busy", {31'd0, moved}, 32'd0);
        check("result_hi", hi, v.exp_hi);
        check("result_lo", lo, v.exp_lo);
        md_op = 4'd7; #1;
        check("mfhi", md_rdata, v.exp_hi);
        md_op = 4'd8; #1;
        check("mflo", md_rdata, v.exp_lo);
        md_op = 4'd0; #1;
        check("rdata_idle_zero", md_rdata, 32'd0);
    endtask

    initial begin
        int          n;
        logic        bad;
        logic [31:0] hi_before;

        vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'd2,          5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{4'd4, 32'd7,         32'd0,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  10, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{4'd4, 32'd100,       32'd7,          10, 32'h0000_0002, 32'h0000_000E};
        vecs[6] = '{4'd3, 32'd7,         32'hFFFF_FFFE,  10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{4'd1, 32'h0001_0000, 32'h0001_0000,  5,  32'h0000_0001, 32'h0000_0000};
        vecs[8] = '{4'd1, 32'h8000_0000, 32'h8000_0000,  5,  32'h4000_0000, 32'h0000_0000};
        vecs[9] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5,  32'hFFFF_FFFE, 32'h0000_0001};

        reset   = 1'b1;
        md_op   = 4'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        md_in_d = 1'b0;
        #22;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_stall", {31'd0, stall_md}, 32'd0);
        reset = 1'b0;
        tick;

        // mthi / mtlo in IDLE
        md_op = 4'd5; rs_data = 32'hA5A5_0001; tick;
        check("mthi_idle", hi, 32'hA5A5_0001);
        md_op = 4'd6; rs_data = 32'h5A5A_0002; tick;
        check("mtlo_idle", lo, 32'h5A5A_0002);
        check("mtlo_keeps_hi", hi, 32'hA5A5_0001);
        md_op = 4'd0;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Stall through a div with md_in_d held; mthi mid-BUSY must be ignored.
        hi_before = hi;
        md_in_d = 1'b1;
        md_op   = 4'd3; rs_data = 32'd100; rt_data = 32'd7;
        #1;
        check("stall_start_cycle", {31'd0, stall_md}, 32'd1);
        tick;
        md_op   = 4'd5; rs_data = 32'hDEAD_BEEF;
        n   = 1;
        bad = 1'b0;
        while (busy && n < 40) begin
            if (!stall_md) bad = 1'b1;
            if (n == 2) begin
                md_op = 4'd7; #1;
                check("mfhi_old_while_busy", md_rdata, hi_before);
                md_op = 4'd0;
            end
            n++;
            tick;
        end
        check("stall_cycles", n, 32'd11);
        check("stall_held", {31'd0, bad}, 32'd0);
        check("stall_released", {31'd0, stall_md}, 32'd0);
        check("mthi_ignored_hi", hi, 32'd2);
        check("div_after_stall_lo", lo, 32'd14);
        md_in_d = 1'b0;

        // Reset at BUSY cycle 3 of a div aborts it and clears HI/LO.
        md_op = 4'd3; rs_data = 32'hFFFF_FFF9; rt_data = 32'd2;
        tick;
        md_op = 4'd0;
        tick;
        tick;
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        #2;
        reset = 1'b0;
        md_op = 4'd5; rs_data = 32'h0000_1234;
        tick;
        check("mthi_after_reset", hi, 32'h0000_1234);
        md_op = 4'd0;

        // Back-to-back: mult 3*4, mflo in the completion cycle, div starts at the next edge.
        md_op = 4'd1; rs_data = 32'd3; rt_data = 32'd4;
        tick;
        md_op = 4'd0; rs_data = $urandom; rt_data = $urandom;
        n = 0;
        while (busy && n < 40) begin n++; tick; end
        check("b2b_mult_cycles", n, 32'd5);
        md_op = 4'd8; #1;
        check("b2b_mflo", md_rdata, 32'd12);
        md_op = 4'd3; rs_data = 32'd100; rt_data = 32'hFFFF_FFF9;
        tick;
        check("b2b_div_started", {31'd0, busy}, 32'd1);
        md_op = 4'd0; rs_data = $urandom; rt_data = $urandom;
        n = 1;
        while (busy && n < 40) begin n++; tick; end
        check("b2b_div_cycles", n, 32'd11);
        check("b2b_div_lo", lo, 32'hFFFF_FFF2);
        check("b2b_div_hi", hi, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
